// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, level type and stall threshold for the FIFO read-side blocks
package fifo_pkg;
  localparam int W_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int STALL_LIMIT = 16;
  typedef logic [1:0] level_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry output buffer; slot0 is the head, pushes land at a caller-chosen index
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [1:0]    i_idx,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);
  logic [DW-1:0] slot0, slot1;
  level_t cnt;
  // a pop shifts slot1 forward; a push at the same index overrides that shift
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      cnt <= cnt + level_t'(i_push) - level_t'(i_pop);
      if (i_pop) slot0 <= slot1;
      if (i_push && i_idx == 2'd0) slot0 <= i_data;
      if (i_push && i_idx == 2'd1) slot1 <= i_data;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_push && !i_pop && cnt == 2'd2));
      assert (!(i_pop && cnt == 2'd0));
    end
  end
  assign o_data = slot0;
  assign o_cnt = cnt;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: empty/read-strobe to valid/ready adapter over a 1-cycle-latency RAM.
// Define FIFO_RD_STREAM_STATS_EN to add the o_pop_cnt / o_stall statistics outputs.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_empty,
  output logic          o_rd,
  input  logic [DW-1:0] i_rdata,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
`ifdef FIFO_RD_STREAM_STATS_EN
  output logic [W+7:0]  o_pop_cnt,
  output logic          o_stall,
`endif
  output logic [1:0]    o_level
);
  level_t cnt, idx;
  logic inflight, pop;
  logic [2:0] occ;
  if (W < 1) begin : g_bad_w
    $error("W must be positive");
  end
  assign o_valid = cnt != 2'd0;
  assign o_level = cnt;
  assign pop = o_valid && i_ready;
  assign occ = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  // combinational from i_ready so a pop frees its slot for a read in the same cycle
  assign o_rd = !i_rst && !i_empty && occ < 3'd2;
  assign idx = cnt - level_t'(pop);
  always_ff @(posedge i_clk) begin
    if (i_rst) inflight <= 1'b0;
    else inflight <= o_rd;
  end
  fifo_rd_skid #(.DW(DW)) u_skid (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_push(inflight),
    .i_idx(idx),
    .i_data(i_rdata),
    .i_pop(pop),
    .o_data(o_data),
    .o_cnt(cnt)
  );
`ifdef FIFO_RD_STREAM_STATS_EN
  localparam int RW = $clog2(STALL_LIMIT);
  logic [RW-1:0] run;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pop_cnt <= '0;
      run <= '0;
      o_stall <= 1'b0;
    end else begin
      if (pop) o_pop_cnt <= o_pop_cnt + {{(W+7){1'b0}}, 1'b1};
      if (o_valid && !i_ready) begin
        run <= run + RW'(run != RW'(STALL_LIMIT - 1));
        if (run == RW'(STALL_LIMIT - 1)) o_stall <= 1'b1;
      end else begin
        run <= '0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and random checks against a queue model of controller, RAM and stream
module tb_fifo_rd_stream;
  logic i_clk = 1'b0;
  logic i_rst, i_empty, o_rd, i_ready, o_valid;
  logic [7:0] i_rdata, o_data;
  logic [1:0] o_level;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] o_pop_cnt;
  logic o_stall;
`endif
  fifo_rd_stream #(.W(8), .DW(8)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_empty(i_empty),
    .o_rd(o_rd),
    .i_rdata(i_rdata),
    .o_valid(o_valid),
    .o_data(o_data),
    .i_ready(i_ready),
`ifdef FIFO_RD_STREAM_STATS_EN
    .o_pop_cnt(o_pop_cnt),
    .o_stall(o_stall),
`endif
    .o_level(o_level)
  );
  always #5 i_clk = ~i_clk;
  int n_cmp = 0, n_err = 0;
  logic [7:0] fifo[$], exp_q[$];
  logic [7:0] rd_word;
  bit last_rd = 0;
  int pops = 0, run = 0;
  bit sticky = 0;
  logic obs_rd, obs_valid;
  logic [7:0] obs_data;
  logic [1:0] obs_level;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock cycle: drive at negedge, check #1 later, advance the model at posedge
  task automatic step(input bit rdy, input bit rst = 0);
    int lvl;
    bit pop, erd;
    i_rst = rst;
    i_ready = rdy;
    i_empty = (fifo.size() == 0);
    i_rdata = last_rd ? rd_word : 8'($urandom);
    #1;
    lvl = exp_q.size() - int'(last_rd);
    pop = (lvl > 0) && rdy;
    erd = !rst && fifo.size() != 0 && (exp_q.size() - int'(pop)) < 2;
    obs_rd = o_rd;
    obs_valid = o_valid;
    obs_data = o_data;
    obs_level = o_level;
    chk("o_rd", o_rd, erd);
    chk("o_level", o_level, lvl);
    chk("o_valid", o_valid, lvl != 0);
    if (lvl != 0) chk("o_data", o_data, exp_q[0]);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("o_pop_cnt", o_pop_cnt, pops);
    chk("o_stall", o_stall, sticky);
`endif
    @(posedge i_clk);
    if (rst) begin
      fifo.delete();
      exp_q.delete();
      last_rd = 0;
      pops = 0;
      run = 0;
      sticky = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        pops++;
      end
      last_rd = erd;
      if (erd) begin
        rd_word = fifo.pop_front();
        exp_q.push_back(rd_word);
      end
      run = (lvl != 0 && !rdy) ? run + 1 : 0;
      if (run >= 16) sticky = 1;
    end
    @(negedge i_clk);
  endtask
  initial begin
    int cnt, gaps, seen, base;
    i_rst = 1;
    i_ready = 1;
    i_empty = 1;
    i_rdata = 0;
    @(negedge i_clk);
    step(1, 1);
    step(1, 1);
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_level", o_level, 2'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      cnt += int'(obs_rd) + int'(obs_valid);
    end
    chk("empty_idle", cnt, 0);
    fifo.push_back(8'hA5);
    step(1);
    chk("single_rd_n", obs_rd, 1'b1);
    step(1);
    chk("single_valid_n1", obs_valid, 1'b0);
    step(1);
    chk("single_valid_n2", obs_valid, 1'b1);
    chk("single_data_n2", obs_data, 8'hA5);
    step(1);
    chk("single_level_n3", obs_level, 2'd0);
    for (int i = 0; i < 16; i++) fifo.push_back(8'(i));
    cnt = 0;
    gaps = 0;
    seen = 0;
    for (int i = 0; i < 40 && cnt < 16; i++) begin
      step(1);
      if (obs_valid) begin
        seen = 1;
        chk("stream_order", obs_data, cnt);
        cnt++;
      end else if (seen) gaps++;
    end
    chk("stream_pops", cnt, 16);
    chk("stream_gaps", gaps, 0);
    for (int i = 0; i < 8; i++) fifo.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) step(0);
    chk("bp_level", obs_level, 2'd2);
    chk("bp_rd", obs_rd, 1'b0);
    chk("bp_data", obs_data, 8'h30);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (obs_valid) begin
        chk("bp_order", obs_data, 8'h30 + 8'(cnt));
        cnt++;
      end
    end
    chk("bp_release_pops", cnt, 8);
    for (int i = 0; i < 4; i++) fifo.push_back(8'hC0 + 8'(i));
    step(0);
    step(0);
    chk("mid_level", o_level, 2'd1);
    step(0, 1);
    chk("mid_rst_rd", obs_rd, 1'b0);
    step(1);
    chk("post_rst_valid", obs_valid, 1'b0);
    chk("post_rst_level", obs_level, 2'd0);
    chk("post_rst_rd", obs_rd, 1'b0);
    step(1);
    chk("late_data_dropped", obs_level, 2'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    for (int i = 0; i < 10; i++) fifo.push_back(8'h50 + 8'(i));
    for (int i = 0; i < 19; i++) step(0);
    chk("stats_stall", o_stall, 1'b1);
    base = pops;
    for (int i = 0; i < 5; i++) step(1);
    chk("stats_pop5", o_pop_cnt, base + 5);
    chk("stats_pop5_abs", o_pop_cnt, 5);
`else
    base = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) fifo.push_back(8'($urandom));
      step(bit'($urandom_range(1)));
    end
    for (int i = 0; i < 60 && (fifo.size() + exp_q.size()) != 0; i++) step(1);
    chk("drain", fifo.size() + exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
